// File: rtl/sonar_pkg.sv
// Shared types and constants for the ultrasonic sonar controller.
package sonar_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRIG      = 2'd1,
        WAIT_ECHO = 2'd2,
        HOLDOFF   = 2'd3
    } sonar_state_t;

    localparam int TIMER_W = 13;
    localparam logic [TIMER_W-1:0] TIMER_MAX = 13'd8191;

    // Width of a counter that must hold the values 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sonar_controller_echo_sync.sv
// Brings the asynchronous sensor echo into the clk domain and flags its rising edges.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // Two metastability flops followed by a delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= async_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    // A steady high level never produces a pulse; only a fresh 0->1 step does.
    assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/sonar_controller.sv
// Sonar ranging controller: fires a trigger pulse, times the echo in ticks,
// reports the result, then waits out a dead time before the next shot.
module sonar_controller
    import sonar_pkg::*;
#(
    parameter int TRIG_CYCLES    = 500,
    parameter int TICK_DIV       = 50,
    parameter int HOLDOFF_CYCLES = 3000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic               echo,
    output logic               trig,
    output logic [TIMER_W-1:0] timer,
    output logic [TIMER_W-1:0] echo_time,
    output logic               valid,
    output logic               timeout,
    output logic               busy
);

    localparam int TRIG_W  = cnt_width(TRIG_CYCLES);
    localparam int PRESC_W = cnt_width(TICK_DIV);
    localparam int HOLD_W  = cnt_width(HOLDOFF_CYCLES);

    localparam logic [TRIG_W-1:0]  TRIG_LAST  = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLDOFF_CYCLES - 1);

    sonar_state_t       state;
    sonar_state_t       state_n;
    logic [TRIG_W-1:0]  trig_cnt;
    logic [TRIG_W-1:0]  trig_cnt_n;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_n;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_cnt_n;
    logic               trig_n;
    logic [TIMER_W-1:0] timer_n;
    logic [TIMER_W-1:0] echo_time_n;
    logic               valid_n;
    logic               timeout_n;
    logic               busy_n;
    logic               echo_rise;

    echo_sync u_echo_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (echo),
        .rise     (echo_rise)
    );

    // State, counters and every output are registered here; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            trig_cnt  <= '0;
            presc     <= '0;
            hold_cnt  <= '0;
            trig      <= 1'b0;
            timer     <= '0;
            echo_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            trig_cnt  <= trig_cnt_n;
            presc     <= presc_n;
            hold_cnt  <= hold_cnt_n;
            trig      <= trig_n;
            timer     <= timer_n;
            echo_time <= echo_time_n;
            valid     <= valid_n;
            timeout   <= timeout_n;
            busy      <= busy_n;
        end
    end

    // Next-state and next-output decode; pulses default low, everything else holds.
    always_comb begin
        state_n     = state;
        trig_cnt_n  = trig_cnt;
        presc_n     = presc;
        hold_cnt_n  = hold_cnt;
        trig_n      = trig;
        timer_n     = timer;
        echo_time_n = echo_time;
        valid_n     = 1'b0;
        timeout_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = TRIG;
                    trig_n     = 1'b1;
                    trig_cnt_n = '0;
                end
            end

            TRIG: begin
                if (trig_cnt == TRIG_LAST) begin
                    state_n = WAIT_ECHO;
                    trig_n  = 1'b0;
                    timer_n = '0;
                    presc_n = '0;
                end else begin
                    trig_cnt_n = trig_cnt + TRIG_W'(1);
                end
            end

            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_n     = HOLDOFF;
                    hold_cnt_n  = '0;
                    echo_time_n = timer;
                    valid_n     = 1'b1;
                end else if (timer == TIMER_MAX) begin
                    state_n     = HOLDOFF;
                    hold_cnt_n  = '0;
                    echo_time_n = TIMER_MAX;
                    timeout_n   = 1'b1;
                end else if (presc == PRESC_LAST) begin
                    presc_n = '0;
                    timer_n = timer + TIMER_W'(1);
                end else begin
                    presc_n = presc + PRESC_W'(1);
                end
            end

            HOLDOFF: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (continuous) begin
                        state_n    = TRIG;
                        trig_n     = 1'b1;
                        trig_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                trig_n  = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_sonar_controller.sv
// Self-checking bench for sonar_controller with short trigger, tick and holdoff settings.
module tb_sonar_controller;

    localparam int TRIG_C   = 4;
    localparam int TICK_D   = 2;
    localparam int HOLD_C   = 10;
    localparam int SAT_TIME = 8191;

    typedef struct {
        int m;
        int exp_time;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        continuous;
    logic        echo;
    logic        trig;
    logic [12:0] timer;
    logic [12:0] echo_time;
    logic        valid;
    logic        timeout;
    logic        busy;

    int errors;
    int checks;
    int valid_seen;
    int timeout_seen;
    bit keep_start;

    sonar_controller #(
        .TRIG_CYCLES    (TRIG_C),
        .TICK_DIV       (TICK_D),
        .HOLDOFF_CYCLES (HOLD_C)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .echo       (echo),
        .trig       (trig),
        .timer      (timer),
        .echo_time  (echo_time),
        .valid      (valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: m is the number of cycles from WAIT_ECHO entry to the cycle whose
    // timer value is captured; the timer advances once per TICK_D cycles and saturates.
    function automatic int model_capture(input int m);
        int t;
        t = m / TICK_D;
        return (t > SAT_TIME) ? SAT_TIME : t;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock and sample just after the edge, tallying output pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        valid_seen   += int'(valid);
        timeout_seen += int'(timeout);
    endtask

    // Called just after the edge before trig should rise. With no timeout, echo is
    // raised so that the timer value m cycles into WAIT_ECHO is the one captured.
    task automatic apply_stimulus(input string tag, input int m, input int exp_time, input bit exp_timeout);
        int v0;
        int t0;
        v0 = valid_seen;
        t0 = timeout_seen;
        tick();
        if (!keep_start) start = 1'b0;
        check_output({tag, "_trig_rise"}, int'(trig), 1);
        check_output({tag, "_busy"}, int'(busy), 1);
        repeat (TRIG_C - 1) tick();
        check_output({tag, "_trig_width"}, int'(trig), 1);
        tick();
        check_output({tag, "_trig_fall"}, int'(trig), 0);
        check_output({tag, "_timer_zero"}, int'(timer), 0);
        if (exp_timeout) begin
            repeat (TICK_D * SAT_TIME) tick();
            check_output({tag, "_timer_sat"}, int'(timer), SAT_TIME);
            check_output({tag, "_no_early_to"}, int'(timeout), 0);
            tick();
            check_output({tag, "_timeout"}, int'(timeout), 1);
            check_output({tag, "_echo_time"}, int'(echo_time), exp_time);
            check_output({tag, "_no_valid"}, int'(valid), 0);
        end else begin
            repeat (m - 2) tick();
            echo = 1'b1;
            tick();
            tick();
            check_output({tag, "_no_early_valid"}, int'(valid), 0);
            tick();
            check_output({tag, "_valid"}, int'(valid), 1);
            check_output({tag, "_no_timeout"}, int'(timeout), 0);
            check_output({tag, "_echo_time"}, int'(echo_time), exp_time);
        end
        check_output({tag, "_valid_count"}, valid_seen - v0, exp_timeout ? 0 : 1);
        check_output({tag, "_timeout_count"}, timeout_seen - t0, exp_timeout ? 1 : 0);
    endtask

    // Called just after the capture edge; optionally wiggles echo to prove extra edges are ignored.
    task automatic run_holdoff(input string tag, input bit cont, input bit toggle);
        int v0;
        v0 = valid_seen;
        for (int i = 1; i <= HOLD_C - 1; i++) begin
            if (i == 1) echo = 1'b0;
            if (toggle && i == 4) echo = 1'b1;
            if (toggle && i == 7) echo = 1'b0;
            if (i == HOLD_C - 1) start = 1'b0;
            tick();
            if (i == 1) check_output({tag, "_valid_one_cycle"}, int'(valid), 0);
        end
        check_output({tag, "_hold_busy"}, int'(busy), 1);
        check_output({tag, "_hold_trig"}, int'(trig), 0);
        if (!cont) begin
            tick();
            check_output({tag, "_idle_busy"}, int'(busy), 0);
            check_output({tag, "_idle_trig"}, int'(trig), 0);
        end
        check_output({tag, "_extra_edges"}, valid_seen - v0, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   m;
        int   v0;

        vecs[0] = '{m: 74,  exp_time: 37};
        vecs[1] = '{m: 75,  exp_time: 37};
        vecs[2] = '{m: 2,   exp_time: 1};
        vecs[3] = '{m: 3,   exp_time: 1};
        vecs[4] = '{m: 41,  exp_time: 20};
        vecs[5] = '{m: 201, exp_time: 100};

        errors       = 0;
        checks       = 0;
        valid_seen   = 0;
        timeout_seen = 0;
        keep_start   = 1'b0;
        reset        = 1'b1;
        start        = 1'b0;
        continuous   = 1'b0;
        echo         = 1'b0;

        tick();
        tick();
        check_output("rst_trig", int'(trig), 0);
        check_output("rst_timer", int'(timer), 0);
        check_output("rst_echo_time", int'(echo_time), 0);
        check_output("rst_valid", int'(valid), 0);
        check_output("rst_timeout", int'(timeout), 0);
        check_output("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        start = 1'b1;
        apply_stimulus("nominal", 74, 37, 1'b0);
        run_holdoff("nominal", 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            apply_stimulus($sformatf("vec%0d", i), vecs[i].m, vecs[i].exp_time, 1'b0);
            run_holdoff($sformatf("vec%0d", i), 1'b0, (i % 2) == 1);
        end

        for (int i = 0; i < 6; i++) begin
            m = int'($urandom_range(600, 2));
            start = 1'b1;
            apply_stimulus($sformatf("rnd%0d", i), m, model_capture(m), 1'b0);
            run_holdoff($sformatf("rnd%0d", i), 1'b0, 1'b1);
        end

        keep_start = 1'b1;
        start = 1'b1;
        apply_stimulus("busy_start", 30, model_capture(30), 1'b0);
        run_holdoff("busy_start", 1'b0, 1'b0);
        keep_start = 1'b0;
        repeat (3) tick();
        check_output("busy_start_not_queued", int'(busy), 0);

        echo = 1'b1;
        repeat (3) tick();
        v0 = valid_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_output("stale_trig", int'(trig), 1);
        repeat (TRIG_C) tick();
        repeat (10) tick();
        check_output("stale_timer5", int'(timer), 5);
        echo = 1'b0;
        repeat (40 - 2 - 10) tick();
        echo = 1'b1;
        repeat (3) tick();
        check_output("stale_valid", int'(valid), 1);
        check_output("stale_echo_time", int'(echo_time), 20);
        check_output("stale_valid_count", valid_seen - v0, 1);
        run_holdoff("stale", 1'b0, 1'b0);

        v0 = valid_seen;
        continuous = 1'b1;
        start = 1'b1;
        apply_stimulus("cont1", 20, 10, 1'b0);
        run_holdoff("cont1", 1'b1, 1'b1);
        apply_stimulus("cont2", 100, 50, 1'b0);
        continuous = 1'b0;
        run_holdoff("cont2", 1'b0, 1'b1);
        check_output("cont_valid_total", valid_seen - v0, 2);

        start = 1'b1;
        apply_stimulus("timeout", 0, SAT_TIME, 1'b1);
        run_holdoff("timeout", 1'b0, 1'b0);

        start = 1'b1;
        apply_stimulus("sat_tie", TICK_D * SAT_TIME, model_capture(TICK_D * SAT_TIME), 1'b0);
        run_holdoff("sat_tie", 1'b0, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (TRIG_C) tick();
        repeat (200) tick();
        check_output("mid_timer100", int'(timer), 100);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_output("mid_rst_trig", int'(trig), 0);
        check_output("mid_rst_timer", int'(timer), 0);
        check_output("mid_rst_echo_time", int'(echo_time), 0);
        check_output("mid_rst_valid", int'(valid), 0);
        check_output("mid_rst_timeout", int'(timeout), 0);
        check_output("mid_rst_busy", int'(busy), 0);
        tick();
        check_output("mid_rst_hold_busy", int'(busy), 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_output("after_rst_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sonar_controller.md
SONAR_CONTROLLER -- requirements
Module: sonar_controller

Interface
REQ-001 Parameter TRIG_CYCLES, default 500, trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-002 Parameter TICK_DIV, default 50, clk cycles per timer tick (1 us at 50 MHz).
REQ-003 Parameter HOLDOFF_CYCLES, default 3000000, dead time between measurements in clk cycles (60 ms).
REQ-004 clk  input  1  system clock; the block SHALL use one clock only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one measurement; level-sampled in IDLE.
REQ-007 continuous  input  1  when 1, re-arm automatically after holdoff.
REQ-008 echo  input  1  asynchronous echo from the sensor.
REQ-009 trig  output  1  trigger pulse to the sensor.
REQ-010 timer  output  13  running tick count since trigger end; feeds the echo capture datapath.
REQ-011 echo_time  output  13  last captured time in ticks.
REQ-012 valid  output  1  one-cycle pulse when echo_time updates from a real echo.
REQ-013 timeout  output  1  one-cycle pulse when no echo arrived before timer saturation.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, TRIG, WAIT_ECHO, HOLDOFF; all outputs registered.
REQ-016 IDLE: start=1 at edge k SHALL give state TRIG and trig=1 from edge k+1.
REQ-017 TRIG: trig SHALL stay high for exactly TRIG_CYCLES cycles, then the block enters WAIT_ECHO with trig=0.
REQ-018 On WAIT_ECHO entry, timer and the prescaler SHALL be 0; timer increments by 1 every TICK_DIV cycles.
REQ-019 echo SHALL pass through a 2-FF synchronizer; only a synchronized 0->1 transition counts as an echo. A level that is already high at WAIT_ECHO entry is not an echo.
REQ-020 An echo edge in WAIT_ECHO SHALL load echo_time with the current timer and pulse valid for one cycle. The valid pulse occurs on the 3rd rising edge after echo is first sampled high. The block then enters HOLDOFF.
REQ-021 timer SHALL saturate at 8191 and never wrap. If timer=8191 with no edge, the block SHALL pulse timeout, load echo_time=8191 and enter HOLDOFF.
REQ-022 Edge and saturation in the same cycle: the echo wins (valid=1, timeout=0, echo_time=8191).
REQ-023 Only the first echo edge per measurement is captured; later edges SHALL be ignored until the next WAIT_ECHO.
REQ-024 HOLDOFF SHALL last HOLDOFF_CYCLES cycles, then go to TRIG if continuous=1, else to IDLE. timer holds its final value during HOLDOFF.
REQ-025 start while busy=1 SHALL be ignored and not queued.
REQ-026 echo_time SHALL hold its value until the next valid or timeout; valid and timeout are never high together.

Reset
REQ-027 reset=1 at any edge, including mid-measurement, SHALL force on the next edge: state=IDLE, trig=0, timer=0, echo_time=0, valid=0, timeout=0, busy=0, prescaler=0, synchronizer flops=0.
REQ-028 reset SHALL take priority over start, echo and all counters.

Structure
REQ-029 Package sonar_pkg SHALL hold the state typedef, TIMER_W=13 and TIMER_MAX=8191.
REQ-030 Sub-module echo_sync SHALL hold the 2-FF synchronizer and rising-edge detector, with ports clk, reset, async_in, rise.
REQ-031 The counters SHALL be sized from the parameters; the default HOLDOFF needs 22 bits.

Verification
REQ-032 The bench SHALL use TRIG_CYCLES=4, TICK_DIV=2, HOLDOFF_CYCLES=10 and cover the scenarios below.
REQ-033 Nominal: start pulse, then echo rises at timer=37 -> trig high for exactly 4 cycles; valid for one cycle; echo_time=37; busy low 10 cycles after valid.
REQ-034 Timeout: start with echo held 0 -> timer reaches 8191, timeout pulses once, echo_time=8191, valid never asserts.
REQ-035 Stale echo: echo=1 before WAIT_ECHO entry, falls at timer=5, rises at timer=20 -> echo_time=20.
REQ-036 Continuous: continuous=1 with echoes at 10, then 50 -> two trig pulses 10 cycles after each capture; echo_time=10, then 50; extra echo edges ignored.
REQ-037 Reset mid-WAIT_ECHO (timer=100) -> next edge all outputs 0, state IDLE; start held high during busy has no effect.
